adaptive_threshold: RTL and testbench
=====================================

Name: adaptive_threshold

Overview:
- Final stage of the adaptive-thresholding pipeline. Runs directly downstream of the 3x3 box-filter stage, while global_state == 2.
- Streams every pixel of the source image and the matching local-mean pixel. Writes a binary pixel (0 or 255) per position to the result memory.
- Throughput is one pixel per clock. Also counts white pixels for host readback.

Parameters:
- WIDTH_BITS, 8, log2 of image width
- HEIGHT_BITS, 8, log2 of image height
- WIDTH, 2**WIDTH_BITS, image width in pixels
- HEIGHT, 2**HEIGHT_BITS, image height in pixels

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- global_state  in  3  system phase; this block is active only at value 2
- iOffset  in  8  threshold offset C, unsigned; sampled on RUN entry
- iInvert  in  1  1 = swap output polarity; sampled on RUN entry
- oImageCol  out  WIDTH_BITS  source-image read X
- oImageRow  out  HEIGHT_BITS  source-image read Y
- iImageData  in  8  source pixel; 1-cycle synchronous read latency
- oMeanCol  out  WIDTH_BITS  mean-memory read X
- oMeanRow  out  HEIGHT_BITS  mean-memory read Y
- iMeanData  in  8  box-filter mean; 1-cycle synchronous read latency
- oResultCol  out  WIDTH_BITS  result write X
- oResultRow  out  HEIGHT_BITS  result write Y
- oResultData  out  8  binary pixel, 0 or 255
- oResultWren  out  1  result write enable, one-cycle pulses
- oWhiteCount  out  WIDTH_BITS+HEIGHT_BITS+1  number of 255 pixels written this run
- finished  out  1  sticky done flag

Behaviour:
- Reset values (synchronous, active-high):
  - state = IDLE; pos = 0.
  - Read addresses 0; oResultCol/Row/Data = 0; oResultWren = 0.
  - oWhiteCount = 0; finished = 0; pipeline valid bits = 0.
- Address generation:
  - pos is a raster index {row, col}, N = WIDTH*HEIGHT.
  - Both read address pairs are driven from pos, so image and mean reads are identical.
  - Addresses are combinational from pos.
- FSM:
  - IDLE -> RUN when global_state == 2 and finished == 0. On this transition: pos = 0, oWhiteCount = 0, iOffset and iInvert latched into registers.
  - RUN: pos increments every cycle. When pos == N-1 it is issued and the FSM goes to DRAIN. pos then holds.
  - DRAIN: waits until the last write has been emitted, then goes to DONE.
  - DONE: finished = 1 and held until reset. No further reads or writes. global_state is ignored.
- Pipeline (k = cycle in which pixel k's address is presented):
  - Cycle k+1: iImageData and iMeanData are valid for pixel k. Compute thr = mean - C as 10-bit signed. hit = (pixel > thr). out = (hit XOR invert) ? 255 : 0.
  - The result is registered at the end of cycle k+1.
  - In cycle k+2: oResultWren = 1, oResultData = out, oResultCol/Row = pixel k's coordinates. Coordinates come from a 2-deep delayed copy of pos.
- Latency and timing:
  - Latency is 2 cycles from address to write.
  - First write occurs in cycle 2 of RUN. Last write occurs in cycle N+1.
  - finished rises in cycle N+2, exactly one cycle after the last write.
  - Exactly N writes are issued, with no gaps.
- Arithmetic and boundary rules:
  - If mean < C, thr is negative, so every pixel is a hit, including 0.
  - If mean = 255 and C = 0, pixel 255 is not a hit (strict greater-than).
  - No saturation is needed; 10-bit signed arithmetic covers -255..255.
- oWhiteCount:
  - Increments in the same cycle a write of 255 is registered.
  - Maximum value is N, which is why the width is +1 bit.
- Abort:
  - If global_state != 2 while in RUN or DRAIN: next cycle state = IDLE, pos = 0, valid bits cleared, oResultWren = 0.
  - Writes already emitted remain. oWhiteCount holds until the next RUN entry clears it.
  - Re-entering global_state == 2 restarts from pixel 0.
- Reset asserted mid-run: all registers return to their reset values on the next edge. No write is emitted in that cycle.

Decomposition:
- Shared package (adaptive_thresh_pkg):
  - Global phase constants: PHASE_IDLE = 0, PHASE_BOX = 1, PHASE_THRESH = 2.
  - FSM state encoding: IDLE, RUN, DRAIN, DONE.
  - Pixel constants: PIX_WHITE = 255, PIX_BLACK = 0.
- One natural sub-module, threshold_compare: combinational (pixel, mean, offset, invert) -> out, hit. Unit-testable exhaustively.
- Raster counter, FSM and delay line stay in the top module.

Test Plan:
1. WIDTH_BITS = HEIGHT_BITS = 2 (N = 16), image all 100, mean all 100, C = 0, invert 0 -> 16 writes of 0 in cycles 2..17; finished in cycle 18; oWhiteCount = 0.
2. Same sizes, image all 100, mean all 100, C = 5 -> all 16 writes = 255; oWhiteCount = 16; coordinates in raster order (0,0), (1,0) … (3,3).
3. Mean = 3, C = 10, image pixel = 0 -> output 255 (negative threshold). Same case with iInvert = 1 -> output 0, oWhiteCount = 0.
4. Image = 255, mean = 255, C = 0 -> output 0. Pixel = 255, mean = 254, C = 0 -> output 255.
5. Drop global_state to 1 after 5 RUN cycles -> oResultWren low the next cycle, state IDLE. Return to 2 -> first write again addresses (0,0); full N writes; finished set.
6. Assert reset in cycle 8 of RUN -> all outputs 0 the next cycle. Raising global_state to 2 afterwards runs a complete fresh pass.

Source files
------------

// File: rtl/adaptive_thresh_pkg.sv
// Shared definitions for the adaptive-threshold stage.
// Contents: global phase codes, FSM state encoding and binary pixel values.
package adaptive_thresh_pkg;

  localparam logic [2:0] PHASE_IDLE   = 3'd0;
  localparam logic [2:0] PHASE_BOX    = 3'd1;
  localparam logic [2:0] PHASE_THRESH = 3'd2;

  localparam logic [7:0] PIX_WHITE = 8'd255;
  localparam logic [7:0] PIX_BLACK = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } thr_state_e;

endpackage

// File: rtl/adaptive_threshold_if.sv
// Memory-side bus of the adaptive-threshold stage.
// Groups the source-image read port, the mean read port and the result
// write port.
//   master : the threshold block (drives addresses and write strobe)
//   slave  : the memories (return read data)
// Handshake: there is no ready signal anywhere on this bus. Read data is
// valid exactly one cycle after an address is presented (fixed latency).
// oResultWren is a one-cycle valid strobe qualifying oResultCol/Row/Data;
// the result memory must accept a write in every cycle it is asserted.
interface adaptive_threshold_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oMeanCol;
  logic [HEIGHT_BITS-1:0] oMeanRow;
  logic [7:0]             iMeanData;
  logic [WIDTH_BITS-1:0]  oResultCol;
  logic [HEIGHT_BITS-1:0] oResultRow;
  logic [7:0]             oResultData;
  logic                   oResultWren;

  modport master (
    output oImageCol, oImageRow, oMeanCol, oMeanRow,
    input  iImageData, iMeanData,
    output oResultCol, oResultRow, oResultData, oResultWren
  );

  modport slave (
    input  oImageCol, oImageRow, oMeanCol, oMeanRow,
    output iImageData, iMeanData,
    input  oResultCol, oResultRow, oResultData, oResultWren
  );
endinterface

// File: rtl/threshold_compare.sv
// Combinational per-pixel threshold decision.
// Ports:
//   i_pixel  : source pixel
//   i_mean   : local mean from the box filter
//   i_offset : threshold offset C (unsigned)
//   i_invert : swap output polarity
//   o_hit    : pixel > (mean - C), signed compare
//   o_out    : 255 when (hit XOR invert), else 0
module threshold_compare
  import adaptive_thresh_pkg::*;
(
  input  logic [7:0] i_pixel,
  input  logic [7:0] i_mean,
  input  logic [7:0] i_offset,
  input  logic       i_invert,
  output logic       o_hit,
  output logic [7:0] o_out
);
  // 10-bit signed covers -255..255, so mean - C never wraps.
  logic signed [9:0] w_thr;
  logic signed [9:0] w_pix;

  assign w_thr = $signed({2'b00, i_mean}) - $signed({2'b00, i_offset});
  assign w_pix = $signed({2'b00, i_pixel});
  assign o_hit = (w_pix > w_thr);
  assign o_out = (o_hit ^ i_invert) ? PIX_WHITE : PIX_BLACK;
endmodule

// File: rtl/adaptive_threshold.sv
// Final adaptive-thresholding stage: streams every source pixel and its
// local mean in raster order, writes a binary pixel per position and
// counts white pixels. One pixel per clock, 2-cycle address-to-write latency.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   global_state   : system phase, active at PHASE_THRESH
//   iOffset        : threshold offset C, latched on RUN entry
//   iInvert        : output polarity swap, latched on RUN entry
//   bus            : image/mean read ports and result write port (master)
//   oWhiteCount    : number of 255 pixels written this run
//   finished       : sticky done flag
//   o_dbg_state    : current FSM state (debug)
module adaptive_threshold
  import adaptive_thresh_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [2:0]                      global_state,
  input  logic [7:0]                      iOffset,
  input  logic                            iInvert,
  adaptive_threshold_if.master            bus,
  output logic [WIDTH_BITS+HEIGHT_BITS:0] oWhiteCount,
  output logic                            finished,
  output thr_state_e                      o_dbg_state
);
  localparam int PB = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [PB-1:0] LAST_POS = '1;
  localparam logic [PB-1:0] ONE_POS  = PB'(1);
  localparam logic [PB:0]   ONE_CNT  = (PB+1)'(1);

  thr_state_e r_state, w_next;

  logic [PB-1:0] r_pos;      // address being presented this cycle
  logic [PB-1:0] r_pos1;     // address whose read data is arriving now
  logic [PB-1:0] r_res_pos;  // coordinates of the write being emitted
  logic          r_v1;       // read data arriving now belongs to a real pixel
  logic          r_wren;
  logic [7:0]    r_res_data;
  logic [PB:0]   r_white;
  logic          r_finished;
  logic [7:0]    r_offset;
  logic          r_invert;

  logic          w_active;
  logic          w_start;
  logic          w_abort;
  logic          w_issue;
  logic          w_hit;
  logic [7:0]    w_out;

  assign w_active = (global_state == PHASE_THRESH);
  assign w_start  = (r_state == ST_IDLE) && w_active && !r_finished;
  assign w_abort  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_active;
  // The address shown in an abort cycle is never followed up.
  assign w_issue  = (r_state == ST_RUN) && w_active;

  threshold_compare u_cmp (
    .i_pixel  (bus.iImageData),
    .i_mean   (bus.iMeanData),
    .i_offset (r_offset),
    .i_invert (r_invert),
    .o_hit    (w_hit),
    .o_out    (w_out)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_RUN;
      ST_RUN: begin
        if (!w_active)              w_next = ST_IDLE;
        else if (r_pos == LAST_POS) w_next = ST_DRAIN;
      end
      // Last write is on the bus and nothing is left behind it.
      ST_DRAIN: begin
        if (!w_active)             w_next = ST_IDLE;
        else if (r_wren && !r_v1)  w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pos      <= '0;
      r_pos1     <= '0;
      r_res_pos  <= '0;
      r_v1       <= 1'b0;
      r_wren     <= 1'b0;
      r_res_data <= '0;
      r_white    <= '0;
      r_finished <= 1'b0;
      r_offset   <= '0;
      r_invert   <= 1'b0;
    end else begin
      r_v1   <= w_issue;
      r_pos1 <= r_pos;
      r_wren <= r_v1 && !w_abort;

      if (r_v1 && !w_abort) begin
        r_res_pos  <= r_pos1;
        r_res_data <= w_out;
        if (w_hit ^ r_invert) r_white <= r_white + ONE_CNT;
      end

      if (w_start) begin
        r_pos    <= '0;
        r_white  <= '0;
        r_offset <= iOffset;
        r_invert <= iInvert;
      end else if (w_abort) begin
        r_pos <= '0;
      end else if ((r_state == ST_RUN) && (r_pos != LAST_POS)) begin
        r_pos <= r_pos + ONE_POS;
      end

      if (w_next == ST_DONE) r_finished <= 1'b1;
    end
  end

  assign bus.oImageCol   = r_pos[WIDTH_BITS-1:0];
  assign bus.oImageRow   = r_pos[PB-1:WIDTH_BITS];
  assign bus.oMeanCol    = r_pos[WIDTH_BITS-1:0];
  assign bus.oMeanRow    = r_pos[PB-1:WIDTH_BITS];
  assign bus.oResultCol  = r_res_pos[WIDTH_BITS-1:0];
  assign bus.oResultRow  = r_res_pos[PB-1:WIDTH_BITS];
  assign bus.oResultData = r_res_data;
  assign bus.oResultWren = r_wren;
  assign oWhiteCount     = r_white;
  assign finished        = r_finished;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_adaptive_threshold.sv
// Self-checking bench for adaptive_threshold on a 4x4 image.
module tb_adaptive_threshold;
  import adaptive_thresh_pkg::*;

  localparam int WB = 2;
  localparam int HB = 2;
  localparam int W  = 1 << WB;
  localparam int H  = 1 << HB;
  localparam int N  = W * H;
  localparam int EW = HB + WB + 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]  global_state = 3'd0;
  logic [7:0]  offset_c = 8'd0;
  logic        invert = 1'b0;
  logic [WB+HB:0] white_count;
  logic        finished;
  thr_state_e  dbg_state;

  adaptive_threshold_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

  adaptive_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
    .clock        (clock),
    .reset        (reset),
    .global_state (global_state),
    .iOffset      (offset_c),
    .iInvert      (invert),
    .bus          (bus),
    .oWhiteCount  (white_count),
    .finished     (finished),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- memory models (1-cycle synchronous read) ----------------
  logic [7:0] img_mem  [N];
  logic [7:0] mean_mem [N];

  always @(posedge clock) begin
    bus.iImageData <= img_mem[{bus.oImageRow, bus.oImageCol}];
    bus.iMeanData  <= mean_mem[{bus.oMeanRow, bus.oMeanCol}];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_white = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: white when pixel strictly exceeds mean - C, polarity optionally swapped.
  function automatic logic [7:0] ref_pixel(input int pix, input int mean, input int c, input bit inv);
    bit white;
    white = (pix > mean - c);
    if (inv) white = !white;
    return white ? 8'd255 : 8'd0;
  endfunction

  // Expected writes for raster pixels 0..n-1 with current offset/invert.
  task automatic push_expected(input int n);
    logic [7:0] d;
    logic [WB-1:0] col;
    logic [HB-1:0] row;
    exp_white = 0;
    for (int k = 0; k < n; k++) begin
      col = WB'(k % W);
      row = HB'(k / W);
      d = ref_pixel(int'(img_mem[k]), int'(mean_mem[k]), int'(offset_c), invert);
      if (d == 8'd255) exp_white++;
      exp_q.push_back({row, col, d});
    end
  endtask

  always @(negedge clock) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    if (bus.oResultWren === 1'b1) begin
      got = {bus.oResultRow, bus.oResultCol, bus.oResultData};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write got=%0h expected=none", got);
      end else begin
        exp = exp_q.pop_front();
        check("write", 32'(got), 32'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_const(input logic [7:0] pix, input logic [7:0] mean);
    for (int k = 0; k < N; k++) begin
      img_mem[k]  = pix;
      mean_mem[k] = mean;
    end
  endtask

  task automatic fill_random();
    int m;
    for (int k = 0; k < N; k++) begin
      img_mem[k] = 8'($urandom_range(0, 255));
      // keep means near the pixel so both outcomes occur
      m = int'(img_mem[k]) + int'($urandom_range(0, 40)) - 20;
      if (m < 0) m = 0;
      if (m > 255) m = 255;
      mean_mem[k] = 8'(m);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    global_state = PHASE_IDLE;
    repeat (2) @(negedge clock);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_wren", 32'(bus.oResultWren), 32'd0);
    check("rst_white", 32'(white_count), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_result", 32'({bus.oResultRow, bus.oResultCol, bus.oResultData}), 32'd0);
    check("rst_addr", 32'({bus.oImageRow, bus.oImageCol, bus.oMeanRow, bus.oMeanCol}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Raise the phase (at a negedge) and follow the run to completion.
  // Cycle 0 is the first cycle in RUN.
  task automatic run_and_check(input string tag);
    int first_wr, last_wr, n_wr, fin_cyc;
    first_wr = -1; last_wr = -1; n_wr = 0; fin_cyc = -1;
    global_state = PHASE_THRESH;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.oResultWren === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
      end
      if (finished === 1'b1) begin
        fin_cyc = cyc;
        break;
      end
    end
    check({tag, "_first_write_cycle"}, 32'(first_wr), 32'd2);
    check({tag, "_last_write_cycle"}, 32'(last_wr), 32'(N + 1));
    check({tag, "_write_count"}, 32'(n_wr), 32'(N));
    check({tag, "_finished_cycle"}, 32'(fin_cyc), 32'(N + 2));
    check({tag, "_white_count"}, 32'(white_count), 32'(exp_white));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    // DONE ignores the phase and stays put
    repeat (3) @(negedge clock);
    check({tag, "_done_hold"}, 32'({finished, dbg_state}), 32'({1'b1, ST_DONE}));
  endtask

  task automatic full_run(input string tag, input logic [7:0] c, input bit inv);
    do_reset();
    offset_c = c;
    invert = inv;
    push_expected(N);
    run_and_check(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // 1: equal pixel and mean, C = 0 -> all black
    fill_const(8'd100, 8'd100);
    full_run("eq_c0", 8'd0, 1'b0);
    // 2: C = 5 -> all white
    full_run("eq_c5", 8'd5, 1'b0);
    // 3: negative threshold makes pixel 0 a hit; then inverted
    fill_const(8'd0, 8'd3);
    full_run("neg_thr", 8'd10, 1'b0);
    full_run("neg_thr_inv", 8'd10, 1'b1);
    // 4: strict greater-than at the top of the range
    for (int k = 0; k < N; k++) begin
      img_mem[k]  = 8'd255;
      mean_mem[k] = (k % 2 == 0) ? 8'd255 : 8'd254;
    end
    full_run("top_edge", 8'd0, 1'b0);
    // random images
    for (int r = 0; r < 4; r++) begin
      fill_random();
      full_run("random", 8'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    // 5: abort after 5 RUN cycles; pixel k is written in cycle k+2,
    // so only pixels 0..2 reach the bus before the abort takes effect.
    do_reset();
    fill_random();
    offset_c = 8'($urandom_range(0, 20));
    invert = 1'b0;
    push_expected(3);
    global_state = PHASE_THRESH;
    repeat (5) @(negedge clock);
    global_state = PHASE_BOX;
    @(negedge clock);
    check("abort_wren", 32'(bus.oResultWren), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_white", 32'(white_count), 32'(exp_white));
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    check("abort_finished", 32'(finished), 32'd0);
    push_expected(N);
    run_and_check("after_abort");

    // 6: reset asserted in cycle 8 of RUN; pixels 0..5 written before it
    do_reset();
    fill_random();
    offset_c = 8'd4;
    invert = 1'b1;
    push_expected(6);
    global_state = PHASE_THRESH;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_wren", 32'(bus.oResultWren), 32'd0);
    check("midrst_outputs", 32'({bus.oResultRow, bus.oResultCol, bus.oResultData, white_count, finished}), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    global_state = PHASE_IDLE;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    push_expected(N);
    run_and_check("after_midrst");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
